// File: rtl/intr_encoder16.sv
`default_nettype none
// ============================================================================
// Module   : intr_encoder16
// Purpose  : Sixteen-line active-low interrupt request encoder with request
//            latch, per-line masking and a valid/ack handshake (0 = highest).
// Revision : 1.0 - initial release
// ============================================================================
module intr_encoder16 #(
    parameter int SYNC = 2
) (
    input  logic        clk_sys,
    input  logic        clr_,
    input  logic [0:15] rq_,
    input  logic [0:15] mask,
    input  logic        ack,
    input  logic        clear_all,
    output logic [3:0]  code,
    output logic        valid,
    output logic [0:15] pending
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFER  = 2'd1,
        S_RETIRE = 2'd2
    } state_t;

    // Stage 0 samples the pins; stage SYNC-1 is the synchronized value.
    logic [SYNC-1:0][0:15] r_sync;
    logic [0:15]           r_prev;
    logic [0:15]           r_latch;
    state_t                r_state;
    logic [3:0]            r_code;
    logic                  r_valid;

    logic [0:15]           w_sync;
    logic [0:15]           w_edge;
    logic [0:15]           w_eligible;
    logic [0:15]           w_clr;
    logic [3:0]            w_first;
    logic                  w_any;
    logic                  w_retire;

    assign w_sync     = r_sync[SYNC-1];
    assign w_edge     = r_prev & ~w_sync;
    assign w_eligible = r_latch & ~mask;
    assign w_any      = |w_eligible;
    assign w_retire   = (r_state == S_OFFER) && ack;

    always_comb begin
        w_first = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_first = 4'(i);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_retire && (r_code == 4'(i))) begin
                w_clr[i] = 1'b1;
            end
        end
        if (clear_all) begin
            w_clr = '1;
        end
    end

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], rq_};
            r_prev <= w_sync;
        end
    end

    // Set beats clear so an edge coinciding with a retire is not lost.
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_latch <= '0;
        end else begin
            r_latch <= (r_latch & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_state <= S_IDLE;
            r_code  <= 4'h0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_any && !clear_all) begin
                        r_code  <= w_first;
                        r_valid <= 1'b1;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_state <= S_RETIRE;
                    end else if (clear_all || mask[r_code]) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RETIRE: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_latch;

endmodule
`default_nettype wire

// File: tb/tb_intr_encoder16.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_encoder16
// Purpose  : Directed self-checking bench for intr_encoder16 (SYNC = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_encoder16;

    logic        clk_sys;
    logic        clr_;
    logic [0:15] rq_;
    logic [0:15] mask;
    logic        ack;
    logic        clear_all;
    logic [3:0]  code;
    logic        valid;
    logic [0:15] pending;

    int n_tests = 0;
    int n_fail  = 0;

    intr_encoder16 #(.SYNC(2)) u_dut (
        .clk_sys   (clk_sys),
        .clr_      (clr_),
        .rq_       (rq_),
        .mask      (mask),
        .ack       (ack),
        .clear_all (clear_all),
        .code      (code),
        .valid     (valid),
        .pending   (pending)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        clr_      = 1'b0;
        rq_       = '1;
        mask      = '0;
        ack       = 1'b0;
        clear_all = 1'b0;
        ticks(3);
        check("reset_valid",   32'(valid),   32'h0);
        check("reset_code",    32'(code),    32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        clr_ = 1'b1;
        ticks(2);

        // Single request on line 5, then hold it low: only one offer.
        rq_[5] = 1'b0;
        ticks(3);
        check("single_early_valid", 32'(valid), 32'h0);
        tick();
        check("single_valid",   32'(valid),   32'h1);
        check("single_code",    32'(code),    32'h5);
        check("single_pending", 32'(pending), 32'h0400);
        pulse_ack();
        check("single_ack_valid",   32'(valid),   32'h0);
        check("single_ack_pending", 32'(pending), 32'h0000);
        ticks(6);
        check("held_low_no_reoffer", 32'(valid), 32'h0);
        rq_[5] = 1'b1;
        ticks(4);
        check("rising_no_request", 32'(pending), 32'h0000);

        // Priority and freeze.
        rq_[9] = 1'b0;
        ticks(4);
        check("prio_code9", 32'(code), 32'h9);
        rq_[2] = 1'b0;
        ticks(5);
        check("freeze_valid",   32'(valid),   32'h1);
        check("freeze_code",    32'(code),    32'h9);
        check("freeze_pending", 32'(pending), 32'h2040);
        pulse_ack();
        check("gap1_valid",   32'(valid),   32'h0);
        check("gap1_pending", 32'(pending), 32'h2000);
        tick();
        check("gap2_valid", 32'(valid), 32'h0);
        tick();
        check("next_valid", 32'(valid), 32'h1);
        check("next_code",  32'(code),  32'h2);
        pulse_ack();
        check("prio_empty", 32'(pending), 32'h0000);
        rq_[2] = 1'b1;
        rq_[9] = 1'b1;
        ticks(4);

        // Mask: latched but not offered; ack in IDLE is ignored.
        mask[3] = 1'b1;
        rq_[3]  = 1'b0;
        ticks(6);
        check("mask_valid",   32'(valid),   32'h0);
        check("mask_pending", 32'(pending), 32'h1000);
        pulse_ack();
        check("idle_ack_ignored", 32'(pending), 32'h1000);
        mask[3] = 1'b0;
        tick();
        check("unmask_valid", 32'(valid), 32'h1);
        check("unmask_code",  32'(code),  32'h3);
        pulse_ack();
        rq_[3] = 1'b1;
        ticks(4);

        // Set-wins: new edge on line 7 coincides with the ack of code 7.
        rq_[7] = 1'b0;
        ticks(4);
        check("sw_code", 32'(code), 32'h7);
        rq_[7] = 1'b1;
        ticks(3);
        rq_[7] = 1'b0;
        ticks(2);
        pulse_ack();
        check("sw_valid",   32'(valid),   32'h0);
        check("sw_pending", 32'(pending), 32'h0100);
        tick();
        check("sw_gap", 32'(valid), 32'h0);
        tick();
        check("sw_reoffer_valid", 32'(valid), 32'h1);
        check("sw_reoffer_code",  32'(code),  32'h7);
        pulse_ack();
        check("sw_done", 32'(pending), 32'h0000);
        rq_[7] = 1'b1;
        ticks(4);

        // clear_all during an offer.
        rq_[1]  = 1'b0;
        rq_[4]  = 1'b0;
        rq_[12] = 1'b0;
        ticks(4);
        check("ca_code",    32'(code),    32'h1);
        check("ca_pending", 32'(pending), 32'h4808);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("ca_valid",       32'(valid),   32'h0);
        check("ca_pending_clr", 32'(pending), 32'h0000);
        ticks(4);
        check("ca_no_offer", 32'(valid), 32'h0);
        rq_[1]  = 1'b1;
        rq_[4]  = 1'b1;
        rq_[12] = 1'b1;
        ticks(4);

        // Reset mid-offer with line 0 held low through release.
        rq_[6] = 1'b0;
        ticks(4);
        check("rst_pre_code", 32'(code), 32'h6);
        rq_[0] = 1'b0;
        clr_   = 1'b0;
        #1;
        check("rst_async_valid",   32'(valid),   32'h0);
        check("rst_async_code",    32'(code),    32'h0);
        check("rst_async_pending", 32'(pending), 32'h0000);
        rq_[6] = 1'b1;
        ticks(2);
        clr_ = 1'b1;
        ticks(3);
        check("rst_rel_early", 32'(valid), 32'h0);
        tick();
        check("rst_rel_valid", 32'(valid), 32'h1);
        check("rst_rel_code",  32'(code),  32'h0);
        pulse_ack();
        ticks(6);
        check("rst_no_second", 32'(valid),   32'h0);
        check("rst_empty",     32'(pending), 32'h0000);
        rq_[0] = 1'b1;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intr_encoder16.md
# intr_encoder16

- Sixteen-line interrupt request encoder with a registered request latch, per-line masking and a valid/ack handshake.
- Mirror of the 4-to-16 line decoder: the decoder turns a 4-bit code into one active-low line; this block collects active-low request lines and presents the highest-priority pending one as a 4-bit code.
- Sits between asynchronous device request wires and the CPU interrupt acceptance logic.
- Line 0 has the highest priority, line 15 the lowest. Code n corresponds to decoder output o_[n].

## Interface
- SYNC, default 2: number of synchronizer flip-flop stages per request line. Legal range is 2..4.
- clk_sys  in  1  system clock; all state changes on its rising edge.
- clr_  in  1  asynchronous, active-low reset.
- rq_  in  [0:15]  active-low request lines. They are asynchronous to clk_sys; a falling edge raises a request.
- mask  in  [0:15]  1 = line masked. A masked request is still latched but is never offered.
- ack  in  1  one-cycle pulse: the consumer accepts the currently offered code.
- clear_all  in  1  one-cycle pulse: discard all latched requests.
- code  out  [3:0]  index of the offered line; bit 0 is the LSB.
- valid  out  1  code is being offered.
- pending  out  [0:15]  latched request bits (1 = pending), shown unmasked.

## Operation
Request capture:
- Each rq_[i] passes through a SYNC-stage synchronizer. All stages reset to 1 (inactive).
- A prev register holds the last synchronized value; it resets to 1.
- Edge detect: edge[i] = prev[i] & ~sync[i], i.e. a 1→0 transition.
- A request is raised by a falling edge only. A line held low raises exactly one request.
- latch[i] is set by edge[i], or cleared by ack-retire of i or by clear_all.
- A set and a clear on the same bit in the same cycle leave the bit set, so a new request is never lost.

Eligible set: latch & ~mask.

State machine (state resets to IDLE):
- IDLE: valid=0.
  - If the eligible set is non-empty, register code = lowest eligible index and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER: valid=1 and code is frozen. A newly arriving higher-priority request does not change code.
  - On ack=1, clear latch[code] (subject to the set-wins rule) and go to RETIRE.
  - On clear_all=1, or when mask[code] becomes 1 without ack, go to IDLE. The offer is withdrawn; the latch bit is untouched unless clear_all.
  - If ack and clear_all arrive together, ack wins: go to RETIRE, and clear_all still clears the latches.
- RETIRE: valid=0. Unconditionally go to IDLE. This state guarantees a gap between offers.
- ack outside OFFER is ignored and has no effect.

Reset values:
- valid=0, code=4'h0, pending=16'h0000, state IDLE.
- Synchronizer and prev registers are all 1.

Reset behaviour:
- Reset mid-offer drops valid immediately (asynchronously) and loses all pending requests.
- A line held low across reset release is seen as a falling edge and latched once, SYNC+1 edges after release.

## Timing
- Edges are numbered from the first rising edge that samples rq_[i]=0.
- Capture latency: sync[i] falls at edge SYNC and latch[i] sets at edge SYNC+1.
- Offer latency from IDLE: valid=1 and code valid after edge SYNC+2.
- Handshake:
  - ack is sampled at edge n while in OFFER.
  - valid=0 and the latch bit is cleared after edge n.
  - The state is IDLE after edge n+1.
  - The next offer appears after edge n+2 at the earliest. Between back-to-back offers, valid is low for exactly 2 cycles.
- Withdrawal (mask or clear_all at edge n in OFFER): valid=0 after edge n. A re-offer is possible after edge n+1.
- pending reflects the latch register directly, with no extra delay.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single request: after reset, drive rq_[5] low (SYNC=2) → valid=1 and code=4'h5 after edge 4. pending=16'h0400 at that time.
- Priority and freeze:
  - Drive rq_[9] low, then rq_[2] low while 9 is offered → code stays 9 until ack.
  - After ack, valid is low for 2 cycles, then code=2.
  - Ack code 2 → pending=0.
- Mask:
  - Set mask[3], then request line 3 → valid stays 0 and pending[3]=1.
  - Clear mask[3] → code=3 offered after 1 edge.
- Set-wins collision: re-pulse rq_[7] so that edge[7] coincides with the ack of code 7 → pending[7] stays 1 and code 7 is offered again 2 cycles later.
- clear_all during OFFER with lines 1, 4 and 12 pending → valid=0 and pending=0 after one edge. No further offers follow.
- Reset mid-offer:
  - Assert clr_=0 while valid=1 → valid=0 and code=0 immediately.
  - Keep rq_[0] held low through reset release → exactly one offer of code 0. After its ack, no second offer.
